// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage constants, queue entry layout and FSM encodings.
package fetch_unit_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned ILEN     = 32;
    localparam int unsigned PC_STEP  = 4;
    localparam int unsigned FQ_DEPTH = 2;

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_STALL = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched {pc, instr} entries with flush; flush wins over push/pop.
module fetch_queue
    import fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = FQ_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push_i,
    input  fetch_entry_t                 push_data_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    output fetch_entry_t                 head_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH):0]       count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    fetch_entry_t    mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            full;
    logic            push_ok;
    logic            pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full | pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = AW'(wr_ptr_q + AW'(1));
            if (pop_ok)  rd_ptr_d = AW'(rd_ptr_q + AW'(1));
            count_d = CW'(count_q + CW'(push_ok) - CW'(pop_ok));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push_ok && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: credit-limited issue to a 1-cycle imem, PC steering,
// redirect flush and a small output queue towards decode.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = FQ_DEPTH
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_cur,
    output logic [XLEN-1:0] pc_next,
    output logic            imem_en,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            fetch_enable,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic            misalign
);

    localparam int unsigned QCW = $clog2(DEPTH) + 1;
    localparam int unsigned CRW = QCW + 1;

    logic [1:0]      state_q, state_d;
    logic            inflight_q, inflight_d;
    logic            drop_q, drop_d;
    logic [XLEN-1:0] tag_q, tag_d;

    fetch_entry_t    q_head;
    fetch_entry_t    q_push_data;
    logic            q_empty;
    logic [QCW-1:0]  q_count;
    logic            q_push;
    logic            pop;
    logic            issue;
    logic [CRW-1:0]  credit_used;

    assign out_valid = ~q_empty & ~redirect_valid;
    assign pop       = out_valid & out_ready;
    assign out_pc    = q_head.pc;
    assign out_instr = q_head.instr;

    // Entries held plus the one in flight, minus the one leaving this cycle.
    assign credit_used = CRW'(CRW'(q_count) + CRW'(inflight_q) - CRW'(pop));
    assign issue       = ~reset & fetch_enable & ~redirect_valid
                       & (credit_used < CRW'(DEPTH));

    assign imem_en   = issue;
    assign imem_addr = pc_cur;
    assign misalign  = ~reset & redirect_valid & (|redirect_target[1:0]);

    assign q_push            = inflight_q & ~drop_q;
    assign q_push_data.pc    = tag_q;
    assign q_push_data.instr = imem_rdata;

    always_comb begin
        pc_next = pc_cur;
        if (redirect_valid) begin
            pc_next = align_word(redirect_target);
        end else if (issue) begin
            pc_next = XLEN'(pc_cur + XLEN'(PC_STEP));
        end
    end

    // State/flag next values; a redirect re-arms drop for any response still in flight.
    always_comb begin
        state_d    = state_q;
        inflight_d = issue;
        drop_d     = 1'b0;
        tag_d      = issue ? pc_cur : tag_q;
        case (state_q)
            S_RUN:   state_d = issue ? S_RUN : S_STALL;
            S_STALL: state_d = issue ? S_RUN : S_STALL;
            S_FLUSH: state_d = S_RUN;
            default: state_d = S_RUN;
        endcase
        if (redirect_valid) begin
            state_d = S_FLUSH;
            drop_d  = inflight_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_RUN;
            inflight_q <= 1'b0;
            drop_q     <= 1'b0;
            tag_q      <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            tag_q      <= tag_d;
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk         (clk),
        .reset       (reset),
        .push_i      (q_push),
        .push_data_i (q_push_data),
        .pop_i       (pop),
        .flush_i     (redirect_valid),
        .head_o      (q_head),
        .empty_o     (q_empty),
        .count_o     (q_count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an external PC register and a 1-cycle imem model.
module tb_fetch_unit;

    localparam logic [31:0] KEY = 32'hA5A5A5A5;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_cur;
    logic [31:0] pc_next;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        fetch_enable;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        misalign;
    logic        pc_load;
    logic [31:0] pc_load_val;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk             (clk),
        .reset           (reset),
        .pc_cur          (pc_cur),
        .pc_next         (pc_next),
        .imem_en         (imem_en),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .fetch_enable    (fetch_enable),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instr       (out_instr),
        .out_pc          (out_pc),
        .misalign        (misalign)
    );

    // PC register, with a bench-side load port to place the PC anywhere.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)        pc_cur <= 32'h0;
        else if (pc_load) pc_cur <= pc_load_val;
        else              pc_cur <= pc_next;
    end

    // Instruction memory: returns addr^KEY one cycle after a strobe, junk otherwise.
    always_ff @(posedge clk) begin
        imem_rdata <= imem_en ? (imem_addr ^ KEY) : 32'hDEADBEEF;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset           = 1'b1;
        fetch_enable    = 1'b0;
        out_ready       = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        pc_load         = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset           = 1'b1;
        fetch_enable    = 1'b1;
        out_ready       = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        pc_load         = 1'b0;
        pc_load_val     = 32'h0;
        tick();
        tick();
        #1;
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_imem_en",   32'(imem_en),   32'h0);
        check("rst_misalign",  32'(misalign),  32'h0);

        // Streaming: one entry per cycle, two cycles after the first issue.
        do_reset();
        fetch_enable = 1'b1;
        out_ready    = 1'b1;
        for (int c = 0; c < 7; c++) begin
            #1;
            if (c == 0) begin
                check("s_addr0",  imem_addr, 32'h0);
                check("s_next0",  pc_next,   32'h4);
                check("s_en0",    32'(imem_en), 32'h1);
            end
            if (c < 2) begin
                check("s_novalid", 32'(out_valid), 32'h0);
            end else begin
                check("s_valid", 32'(out_valid), 32'h1);
                check("s_pc",    out_pc,    32'(4 * (c - 2)));
                check("s_instr", out_instr, 32'(4 * (c - 2)) ^ KEY);
            end
            tick();
        end

        // Decode stalled from the start: queue fills with pc 0 and 4, then drains.
        do_reset();
        fetch_enable = 1'b1;
        out_ready    = 1'b0;
        repeat (5) tick();
        #1;
        check("f_valid",   32'(out_valid), 32'h1);
        check("f_pc",      out_pc,  32'h0);
        check("f_en",      32'(imem_en), 32'h0);
        check("f_pc_cur",  pc_cur,  32'h8);
        check("f_pc_next", pc_next, 32'h8);
        fetch_enable = 1'b0;
        out_ready    = 1'b1;
        #1;
        check("d_pc0", out_pc, 32'h0);
        tick();
        #1;
        check("d_pc1",    out_pc,    32'h4);
        check("d_instr1", out_instr, 32'h4 ^ KEY);
        check("d_valid1", 32'(out_valid), 32'h1);
        tick();
        #1;
        check("d_empty", 32'(out_valid), 32'h0);
        check("d_hold",  pc_next, 32'h8);

        // Redirect to 0x100 while the 0x10 response is in flight.
        do_reset();
        fetch_enable = 1'b1;
        out_ready    = 1'b1;
        repeat (5) tick();
        redirect_valid  = 1'b1;
        redirect_target = 32'h100;
        #1;
        check("r_pc_cur",  pc_cur, 32'h14);
        check("r_valid",   32'(out_valid), 32'h0);
        check("r_en",      32'(imem_en),   32'h0);
        check("r_next",    pc_next, 32'h100);
        check("r_misal",   32'(misalign), 32'h0);
        tick();
        redirect_valid = 1'b0;
        #1;
        check("r_addr",   imem_addr, 32'h100);
        check("r_en1",    32'(imem_en), 32'h1);
        tick();
        #1;
        check("r_gap",    32'(out_valid), 32'h0);
        tick();
        #1;
        check("r_valid3", 32'(out_valid), 32'h1);
        check("r_pc3",    out_pc,    32'h100);
        check("r_instr3", out_instr, 32'h100 ^ KEY);
        tick();
        #1;
        check("r_pc4",    out_pc, 32'h104);

        // Misaligned redirect, then back-to-back redirects where the last wins.
        tick();
        redirect_valid  = 1'b1;
        redirect_target = 32'h103;
        #1;
        check("m_pulse", 32'(misalign), 32'h1);
        check("m_next",  pc_next, 32'h100);
        tick();
        redirect_valid = 1'b0;
        #1;
        check("m_clear", 32'(misalign), 32'h0);
        check("m_addr",  imem_addr, 32'h100);
        check("m_en",    32'(imem_en), 32'h1);
        tick();
        redirect_valid  = 1'b1;
        redirect_target = 32'h203;
        #1;
        check("b_pulse", 32'(misalign), 32'h1);
        tick();
        redirect_target = 32'h200;
        #1;
        check("b_misal", 32'(misalign), 32'h0);
        check("b_next",  pc_next, 32'h200);
        tick();
        redirect_valid = 1'b0;
        #1;
        check("b_addr",  imem_addr, 32'h200);
        tick();
        #1;
        check("b_gap",   32'(out_valid), 32'h0);
        tick();
        #1;
        check("b_valid", 32'(out_valid), 32'h1);
        check("b_pc",    out_pc, 32'h200);

        // PC wrap from the top of the address space.
        do_reset();
        out_ready    = 1'b1;
        pc_load      = 1'b1;
        pc_load_val  = 32'hFFFFFFFC;
        tick();
        pc_load      = 1'b0;
        fetch_enable = 1'b1;
        #1;
        check("w_addr", imem_addr, 32'hFFFFFFFC);
        check("w_next", pc_next,   32'h0);
        tick();
        #1;
        check("w_wrap", pc_cur, 32'h0);
        tick();
        #1;
        check("w_pc",    out_pc,    32'hFFFFFFFC);
        check("w_instr", out_instr, 32'h5A5A5A59);

        // Reset with an entry queued and a fetch in flight.
        do_reset();
        fetch_enable = 1'b1;
        out_ready    = 1'b0;
        tick();
        tick();
        #1;
        check("x_pre_valid", 32'(out_valid), 32'h1);
        reset = 1'b1;
        #1;
        check("x_valid", 32'(out_valid), 32'h0);
        check("x_en",    32'(imem_en),   32'h0);
        tick();
        reset        = 1'b0;
        fetch_enable = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("x_after", 32'(out_valid), 32'h0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
